// File: rtl/dmem_if.sv
// Core-side data port bundle of the data-memory controller: request fields
// driven by the core (master) and the completion response from memory (slave).
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, size, unsigned_ld, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, size, unsigned_ld, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready handshake with LATENCY wait states, byte/half/word
// RAM access with load extension, tohost + cycle-counter MMIO. Optional MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_reg;
    logic [CW-1:0] wait_reg;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [1:0]    size_reg;
    logic          uns_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   cycle_reg;
    logic [31:0]   ram_q_reg;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          done;
    logic          size_byte;
    logic          size_half;
    logic          size_word;
    logic          is_ram;
    logic          is_mmio;
    logic          misalign;
    logic [3:0]    byte_en;
    logic [31:0]   wlane;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [31:0]   ram_load;
    logic [31:0]   mmio_load;
    logic          ram_wr;
    logic          tohost_wr;

    assign accept = (state_reg == S_IDLE) && bus.req;
    assign done   = (state_reg == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            wait_reg  <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= '0;
            uns_reg   <= 1'b0;
            wdata_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req) begin
                        we_reg    <= bus.we;
                        addr_reg  <= bus.addr;
                        size_reg  <= bus.size;
                        uns_reg   <= bus.unsigned_ld;
                        wdata_reg <= bus.wdata;
                        wait_reg  <= CW'(LATENCY - 1);
                        state_reg <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_reg <= wait_reg - 1'b1;
                    if (wait_reg == CW'(1)) begin
                        state_reg <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Size code 3 behaves as a word access.
    assign size_byte = (size_reg == 2'd0);
    assign size_half = (size_reg == 2'd1);
    assign size_word = size_reg[1];

    assign is_ram  = (addr_reg[31:AW+2] == '0);
    assign is_mmio = (addr_reg[31:3] == MMIO_BASE[31:3]);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (size_half && addr_reg[0]) || (size_word && (addr_reg[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Right-aligned store data is replicated so each enabled lane sees its own slice.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign byte_en[gi] = size_word
                          || (size_half && (addr_reg[1] == LANE[1]))
                          || (size_byte && (addr_reg[1:0] == LANE));
        assign wlane[gi*8 +: 8] = size_word ? wdata_reg[gi*8 +: 8]
                                : size_half ? wdata_reg[(gi%2)*8 +: 8]
                                : wdata_reg[7:0];
    end

    assign byte_val = ram_q_reg[{addr_reg[1:0], 3'b000} +: 8];
    assign half_val = addr_reg[1] ? ram_q_reg[31:16] : ram_q_reg[15:0];

    always_comb begin
        ram_load = ram_q_reg;
        if (size_half) begin
            ram_load = {(uns_reg ? 16'h0000 : {16{half_val[15]}}), half_val};
        end else if (size_byte) begin
            ram_load = {(uns_reg ? 24'h00_0000 : {24{byte_val[7]}}), byte_val};
        end
    end

    assign mmio_load = addr_reg[2] ? cycle_reg : tohost_data;

    always_comb begin
        bus.rdata = 32'h0;
        if (done && !misalign) begin
            if (is_ram) begin
                bus.rdata = ram_load;
            end else if (is_mmio) begin
                bus.rdata = mmio_load;
            end
        end
    end

    assign bus.ready = done;
    assign bus.err   = done && misalign;

    assign ram_wr    = done && we_reg && is_ram && !misalign;
    assign tohost_wr = done && we_reg && !is_ram && is_mmio && !addr_reg[2] && !misalign;

    // Read is launched at acceptance so the registered output is stable by DONE;
    // the previous store has always committed before the next acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            ram_q_reg <= mem[bus.addr[AW+1:2]];
        end
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_reg[AW+1:2]][i*8 +: 8] <= wlane[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
            cycle_reg    <= '0;
        end else begin
            tohost_valid <= tohost_wr;
            if (tohost_wr) begin
                tohost_data <= wdata_reg;
            end
            cycle_reg <= cycle_reg + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: one LATENCY=3 instance for the main function
// and a LATENCY=4 instance for the mid-transaction reset case.
module tb_dmem_ctrl;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset3 = 1'b1;
    logic        reset4 = 1'b1;
    logic        tohost_valid3, tohost_valid4;
    logic [31:0] tohost_data3, tohost_data4;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    dmem_if bus3();
    dmem_if bus4();

    dmem_ctrl #(.DEPTH(1024), .LATENCY(3), .MMIO_BASE(MMIO_BASE)) u_dut3 (
        .clk(clk), .reset(reset3), .bus(bus3),
        .tohost_valid(tohost_valid3), .tohost_data(tohost_data3)
    );

    dmem_ctrl #(.DEPTH(1024), .LATENCY(4), .MMIO_BASE(MMIO_BASE)) u_dut4 (
        .clk(clk), .reset(reset4), .bus(bus4),
        .tohost_valid(tohost_valid4), .tohost_data(tohost_data4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic access(input bit sel4, input bit w, input logic [31:0] a,
                          input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int done_cyc);
        @(posedge clk); #1;
        if (sel4) begin
            bus4.we = w; bus4.addr = a; bus4.size = sz; bus4.unsigned_ld = uns;
            bus4.wdata = wd; bus4.req = 1'b1;
        end else begin
            bus3.we = w; bus3.addr = a; bus3.size = sz; bus3.unsigned_ld = uns;
            bus3.wdata = wd; bus3.req = 1'b1;
        end
        @(posedge clk); #1;
        lat = 1;
        while (!(sel4 ? bus4.ready : bus3.ready) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(sel4 ? bus4.ready : bus3.ready)) lat = -1;
        rd       = sel4 ? bus4.rdata : bus3.rdata;
        er       = sel4 ? bus4.err : bus3.err;
        done_cyc = cyc;
        bus3.req = 1'b0;
        bus4.req = 1'b0;
        $display("txn dut%0d %s addr=%h size=%0d uns=%0b wdata=%h -> rdata=%h err=%0b lat=%0d",
                 sel4 ? 4 : 3, w ? "ST" : "LD", a, sz, uns, wd, rd, er, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus3.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready3: got %b expected 0", bus3.ready); end
        vectors++; if (bus3.err !== 1'b0) begin miscompares++; $display("FAIL reset_err3: got %b expected 0", bus3.err); end
        vectors++; if (bus3.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata3: got %h expected 0", bus3.rdata); end
        vectors++; if (tohost_valid3 !== 1'b0) begin miscompares++; $display("FAIL reset_tohost_valid3: got %b expected 0", tohost_valid3); end
        vectors++; if (tohost_data3 !== 32'h0) begin miscompares++; $display("FAIL reset_tohost_data3: got %h expected 0", tohost_data3); end
        vectors++; if (bus4.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready4: got %b expected 0", bus4.ready); end
        vectors++; if (tohost_data4 !== 32'h0) begin miscompares++; $display("FAIL reset_tohost_data4: got %h expected 0", tohost_data4); end
        reset3 = 1'b0;
        reset4 = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus3.ready !== 1'b0) begin miscompares++; $display("FAIL post_reset_ready: got %b expected 0", bus3.ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat, dc;
        access(0, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, rd, er, lat, dc);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL store_latency: got %0d expected 3", lat); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL store_err: got %b expected 0", er); end
        @(posedge clk); #1;
        vectors++; if (bus3.ready !== 1'b0) begin miscompares++; $display("FAIL ready_single_pulse: got %b expected 0", bus3.ready); end
        access(0, 0, 32'h10, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_word: got %h expected deadbeef", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL load_err: got %b expected 0", er); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL load_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_extension();
        logic [31:0] rd; logic er; int lat, dc;
        access(0, 1, 32'h20, 2'd2, 0, 32'h8081_7F80, rd, er, lat, dc);
        access(0, 0, 32'h20, 2'd0, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL byte_signed: got %h expected ffffff80", rd); end
        access(0, 0, 32'h20, 2'd0, 1, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h0000_0080) begin miscompares++; $display("FAIL byte_unsigned: got %h expected 00000080", rd); end
        access(0, 0, 32'h21, 2'd0, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h0000_007F) begin miscompares++; $display("FAIL byte1_signed: got %h expected 0000007f", rd); end
        access(0, 0, 32'h22, 2'd1, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'hFFFF_8081) begin miscompares++; $display("FAIL half_signed: got %h expected ffff8081", rd); end
        access(0, 0, 32'h22, 2'd1, 1, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h0000_8081) begin miscompares++; $display("FAIL half_unsigned: got %h expected 00008081", rd); end
        access(0, 1, 32'h21, 2'd0, 0, 32'hAAAA_AA11, rd, er, lat, dc);
        access(0, 0, 32'h20, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h8081_1180) begin miscompares++; $display("FAIL byte_store: got %h expected 80811180", rd); end
        access(0, 1, 32'h22, 2'd1, 0, 32'h1234_BEEF, rd, er, lat, dc);
        access(0, 0, 32'h20, 2'd3, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'hBEEF_1180) begin miscompares++; $display("FAIL half_store: got %h expected beef1180", rd); end
    endtask

    task automatic test_mmio();
        logic [31:0] rd, r1, r2; logic er; int lat, c1, c2;
        access(0, 1, MMIO_BASE, 2'd2, 0, 32'h1, rd, er, lat, c1);
        vectors++; if (tohost_valid3 !== 1'b0) begin miscompares++; $display("FAIL tohost_valid_early: got %b expected 0", tohost_valid3); end
        @(posedge clk); #1;
        vectors++; if (tohost_valid3 !== 1'b1) begin miscompares++; $display("FAIL tohost_valid_pulse: got %b expected 1", tohost_valid3); end
        vectors++; if (tohost_data3 !== 32'h1) begin miscompares++; $display("FAIL tohost_data: got %h expected 00000001", tohost_data3); end
        @(posedge clk); #1;
        vectors++; if (tohost_valid3 !== 1'b0) begin miscompares++; $display("FAIL tohost_valid_single: got %b expected 0", tohost_valid3); end
        access(0, 1, MMIO_BASE, 2'd0, 0, 32'hCAFE_F00D, rd, er, lat, c1);
        access(0, 1, MMIO_BASE + 32'd4, 2'd2, 0, 32'h1234_5678, rd, er, lat, c1);
        access(0, 0, MMIO_BASE, 2'd2, 0, 32'h0, rd, er, lat, c1);
        vectors++; if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL tohost_readback: got %h expected cafef00d", rd); end
        access(0, 0, MMIO_BASE + 32'd4, 2'd2, 0, 32'h0, r1, er, lat, c1);
        repeat (10) @(posedge clk);
        access(0, 0, MMIO_BASE + 32'd4, 2'd2, 0, 32'h0, r2, er, lat, c2);
        vectors++; if ((r2 - r1) !== 32'(c2 - c1)) begin miscompares++; $display("FAIL cycle_delta: got %0d expected %0d", r2 - r1, c2 - c1); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic er; int lat, dc, bad;
        logic [31:0] snap [1024];
        access(0, 1, 32'h0, 2'd2, 0, 32'h0BAD_F00D, rd, er, lat, dc);
        access(0, 0, 32'h4000_0000, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL unmapped_load: got %h expected 0", rd); end
        vectors++; if (lat !== 3 || er !== 1'b0) begin miscompares++; $display("FAIL unmapped_ready: got lat=%0d err=%b expected lat=3 err=0", lat, er); end
        for (int i = 0; i < 1024; i++) begin
            access(0, 0, 32'(i * 4), 2'd2, 0, 32'h0, snap[i], er, lat, dc);
        end
        access(0, 1, 32'h4000_0000, 2'd2, 0, 32'h1234_5678, rd, er, lat, dc);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL unmapped_store_ready: got %0d expected 3", lat); end
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            access(0, 0, 32'(i * 4), 2'd2, 0, 32'h0, rd, er, lat, dc);
            if (rd !== snap[i]) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL unmapped_store_readback: got %0d changed words expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, dc, seen;
        access(1, 1, 32'h0, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lat4_store: got %0d expected 4", lat); end
        @(posedge clk); #1;
        bus4.we = 1'b1; bus4.addr = 32'h0; bus4.size = 2'd2; bus4.wdata = 32'h5555_5555; bus4.req = 1'b1;
        seen = 0;
        @(posedge clk); #1;
        bus4.req = 1'b0;
        seen += int'(bus4.ready);
        @(posedge clk); #1;
        seen += int'(bus4.ready);
        reset4 = 1'b1;
        @(posedge clk); #1;
        reset4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen += int'(bus4.ready);
            @(posedge clk); #1;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL reset_mid_ready: got %0d ready cycles expected 0", seen); end
        access(1, 0, 32'h0, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_mid_commit: got %h expected 0", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat, dc;
        logic [31:0] exp_w, exp_h, exp_st;
        logic exp_err;
`ifdef MISALIGN_TRAP_EN
        exp_w = 32'h0; exp_h = 32'h0; exp_st = 32'h0102_0304; exp_err = 1'b1;
`else
        exp_w = 32'h0102_0304; exp_h = 32'h0000_1180; exp_st = 32'hFFFF_FFFF; exp_err = 1'b0;
`endif
        access(0, 1, 32'h0, 2'd2, 0, 32'h0102_0304, rd, er, lat, dc);
        access(0, 0, 32'h3, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== exp_w) begin miscompares++; $display("FAIL misalign_word_rdata: got %h expected %h", rd, exp_w); end
        vectors++; if (er !== exp_err) begin miscompares++; $display("FAIL misalign_word_err: got %b expected %b", er, exp_err); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL misalign_latency: got %0d expected 3", lat); end
        access(0, 0, 32'h21, 2'd1, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== exp_h || er !== exp_err) begin miscompares++; $display("FAIL misalign_half: got %h/%b expected %h/%b", rd, er, exp_h, exp_err); end
        access(0, 1, 32'h1, 2'd2, 0, 32'hFFFF_FFFF, rd, er, lat, dc);
        access(0, 0, 32'h0, 2'd2, 0, 32'h0, rd, er, lat, dc);
        vectors++; if (rd !== exp_st) begin miscompares++; $display("FAIL misalign_store: got %h expected %h", rd, exp_st); end
    endtask

    initial begin
        bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr = '0; bus3.size = '0; bus3.unsigned_ld = 1'b0; bus3.wdata = '0;
        bus4.req = 1'b0; bus4.we = 1'b0; bus4.addr = '0; bus4.size = '0; bus4.unsigned_ld = 1'b0; bus4.wdata = '0;
        test_reset();
        test_word();
        test_extension();
        test_mmio();
        test_unmapped();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
